// File: rtl/fpu_pkg.sv
// Shared binary32 types, constants and pipeline stage records for the FPU cluster.
// Denormal behaviour of the subtractor is selected by FSUB_DENORM_EN (default: flush-to-zero).
package fpu_pkg;

  typedef struct packed {
    logic        sign;
    logic [7:0]  exp;
    logic [22:0] man;
  } float32_t;

  localparam logic [7:0]  EXP_MAX = 8'hff;
  localparam int unsigned BIAS    = 127;
  localparam logic [31:0] QNAN    = 32'h7fc00000;

  typedef enum logic [2:0] {ZERO, DENORM, NORMAL, INF, NAN} class_e;

  function automatic class_e classify(input float32_t f);
    if (f.exp == EXP_MAX) return (f.man == '0) ? INF : NAN;
    if (f.exp == '0)      return (f.man == '0) ? ZERO : DENORM;
    return NORMAL;
  endfunction

  // sig_a/sig_b: {hidden, man[22:0], guard, round, sticky}
  typedef struct packed {
    logic        special;
    logic [31:0] special_val;
    logic        in_maxexp;
    logic        sign;
    logic        sub;
    logic [7:0]  exp;
    logic [26:0] sig_a;
    logic [26:0] sig_b;
  } s1_t;

  typedef struct packed {
    logic        special;
    logic [31:0] special_val;
    logic        in_maxexp;
    logic        sign;
    logic        sub;
    logic [7:0]  exp;
    logic [27:0] sum;
    logic [4:0]  lzc;
  } s2_t;

  typedef struct packed {
    logic [31:0] y;
    logic        ovf;
  } res_t;

endpackage

// File: rtl/fsub_lzc.sv
// 27-bit leading-zero counter; an all-zero input reports 27.
module fsub_lzc (
  input  logic [26:0] a,
  output logic [4:0]  cnt
);

  // Ascending scan: the highest set bit is the last one to write cnt.
  always_comb begin
    cnt = 5'd27;
    for (int unsigned i = 0; i < 27; i++) begin
      if (a[i]) cnt = 5'(26 - i);
    end
  end

endmodule

// File: rtl/fsub_pipe.sv
// 3-stage valid/ready binary32 subtractor y = x1 - x2 (RNE) with overflow flag.
// FSUB_DENORM_EN defined: gradual underflow; undefined: flush-to-zero.
module fsub_pipe
  import fpu_pkg::*;
#(
  parameter int unsigned OUT_REG = 1
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] x1,
  input  logic [31:0] x2,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] y,
  output logic        ovf
);

  localparam logic signed [9:0] E_OVF = 10'(2 * BIAS + 1);

  logic s1_valid_q, s1_valid_d, s2_valid_q, s2_valid_d;
  s1_t  s1_q, s1_d, s1_c;
  s2_t  s2_q, s2_d, s2_c;
  res_t res;
  logic s1_load, s2_load, s2_next_free;

  assign s2_load  = !s2_valid_q || s2_next_free;
  assign s1_load  = !s1_valid_q || s2_load;
  assign in_ready = s1_load;

  // ---------------- S1: unpack, classify, swap, align ----------------
  float32_t   fa, fb;
  class_e     ca, cb;
  logic [7:0] ea, eb, e_big, e_small, diff;
  logic [23:0] ma, mb, m_big, m_small;
  logic [4:0]  dsh;
  logic [26:0] sig_small, lost;
  logic        swap;

  always_comb begin
    fa = x1;
    fb = {~x2[31], x2[30:0]};
    ca = classify(fa);
    cb = classify(fb);
`ifdef FSUB_DENORM_EN
    ea = (fa.exp == '0) ? 8'd1 : fa.exp;
    eb = (fb.exp == '0) ? 8'd1 : fb.exp;
    ma = {fa.exp != '0, fa.man};
    mb = {fb.exp != '0, fb.man};
`else
    ea = fa.exp;
    eb = fb.exp;
    ma = (fa.exp == '0) ? '0 : {1'b1, fa.man};
    mb = (fb.exp == '0) ? '0 : {1'b1, fb.man};
`endif
    swap      = {eb, mb} > {ea, ma};
    e_big     = swap ? eb : ea;
    e_small   = swap ? ea : eb;
    m_big     = swap ? mb : ma;
    m_small   = swap ? ma : mb;
    diff      = e_big - e_small;
    dsh       = (diff > 8'd26) ? 5'd26 : diff[4:0];
    sig_small = {m_small, 3'b000};
    lost      = sig_small & ((27'd1 << dsh) - 27'd1);

    s1_c.sign      = swap ? fb.sign : fa.sign;
    s1_c.sub       = fa.sign ^ fb.sign;
    s1_c.exp       = e_big;
    s1_c.sig_a     = {m_big, 3'b000};
    s1_c.sig_b     = (sig_small >> dsh) | {26'd0, |lost};
    s1_c.in_maxexp = (fa.exp == EXP_MAX) || (fb.exp == EXP_MAX);

    s1_c.special     = 1'b1;
    s1_c.special_val = '0;
    if (ca == NAN)                   s1_c.special_val = x1 | 32'h0040_0000;
    else if (cb == NAN)              s1_c.special_val = x2 | 32'h0040_0000;
    else if (ca == INF && cb == INF) s1_c.special_val = (fa.sign != fb.sign) ? QNAN : fa;
    else if (ca == INF)              s1_c.special_val = fa;
    else if (cb == INF)              s1_c.special_val = fb;
    else                             s1_c.special     = 1'b0;
  end

  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_d       = s1_q;
    if (s1_load) begin
      s1_valid_d = in_valid;
      if (in_valid) s1_d = s1_c;
    end
  end

  // ---------------- S2: significand add/sub, leading zeros ----------------
  logic [27:0] sum_c;
  logic [4:0]  lzc_c;

  assign sum_c = s1_q.sub ? ({1'b0, s1_q.sig_a} - {1'b0, s1_q.sig_b})
                          : ({1'b0, s1_q.sig_a} + {1'b0, s1_q.sig_b});

  fsub_lzc u_lzc (
    .a   (sum_c[26:0]),
    .cnt (lzc_c)
  );

  always_comb begin
    s2_c.special     = s1_q.special;
    s2_c.special_val = s1_q.special_val;
    s2_c.in_maxexp   = s1_q.in_maxexp;
    s2_c.sign        = s1_q.sign;
    s2_c.sub         = s1_q.sub;
    s2_c.exp         = s1_q.exp;
    s2_c.sum         = sum_c;
    s2_c.lzc         = lzc_c;
  end

  always_comb begin
    s2_valid_d = s2_valid_q;
    s2_d       = s2_q;
    if (s2_load) begin
      s2_valid_d = s1_valid_q;
      if (s1_valid_q) s2_d = s2_c;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      s1_valid_q <= 1'b0;
      s2_valid_q <= 1'b0;
      s1_q       <= '0;
      s2_q       <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s2_valid_q <= s2_valid_d;
      s1_q       <= s1_d;
      s2_q       <= s2_d;
    end
  end

  // ---------------- S3: normalise, round, pack ----------------
  logic [26:0]       norm;
  logic [4:0]        sh;
  logic signed [9:0] e_norm, e_fin;
  logic [24:0]       rnd;
  logic [22:0]       man;
  logic              rup;
`ifdef FSUB_DENORM_EN
  logic [7:0]        lim;
`endif

  always_comb begin
    norm   = '0;
    sh     = '0;
    e_norm = '0;
    e_fin  = '0;
    man    = '0;
    res    = '0;
`ifdef FSUB_DENORM_EN
    lim    = s2_q.exp - 8'd1;
`endif
    if (s2_q.sum[27]) begin
      norm   = {s2_q.sum[27:2], s2_q.sum[1] | s2_q.sum[0]};
      e_norm = $signed({2'b00, s2_q.exp}) + 10'sd1;
    end else begin
`ifdef FSUB_DENORM_EN
      // Stop the shift at exponent 1 so small results stay denormal.
      sh = ({3'b000, s2_q.lzc} > lim) ? lim[4:0] : s2_q.lzc;
`else
      sh = s2_q.lzc;
`endif
      norm   = s2_q.sum[26:0] << sh;
      e_norm = $signed({2'b00, s2_q.exp}) - $signed({5'b00000, sh});
    end

    rup = norm[2] & (norm[1] | norm[0] | norm[3]);
    rnd = {1'b0, norm[26:3]} + 25'(rup);
    if (rnd[24]) begin
      e_fin = e_norm + 10'sd1;
      man   = rnd[23:1];
    end else begin
      e_fin = rnd[23] ? e_norm : 10'sd0;
      man   = rnd[22:0];
    end

    if (s2_q.special)          res.y = s2_q.special_val;
    else if (s2_q.sum == '0)   res.y = {s2_q.sub ? 1'b0 : s2_q.sign, 31'd0};
    else if (e_fin >= E_OVF)   res.y = {s2_q.sign, EXP_MAX, 23'd0};
`ifndef FSUB_DENORM_EN
    else if (e_fin <= 10'sd0)  res.y = {s2_q.sign, 31'd0};
`endif
    else                       res.y = {s2_q.sign, e_fin[7:0], man};
    res.ovf = !s2_q.in_maxexp && (res.y[30:23] == EXP_MAX);
  end

  generate
    if (OUT_REG != 0) begin : g_out_reg
      logic s3_valid_q, s3_valid_d, s3_load;
      res_t s3_q, s3_d;

      assign s3_load      = !s3_valid_q || out_ready;
      assign s2_next_free = s3_load;

      always_comb begin
        s3_valid_d = s3_valid_q;
        s3_d       = s3_q;
        if (s3_load) begin
          s3_valid_d = s2_valid_q;
          if (s2_valid_q) s3_d = res;
        end
      end

      always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
          s3_valid_q <= 1'b0;
          s3_q       <= '0;
        end else begin
          s3_valid_q <= s3_valid_d;
          s3_q       <= s3_d;
        end
      end

      assign out_valid = s3_valid_q;
      assign y         = s3_q.y;
      assign ovf       = s3_q.ovf;
    end else begin : g_out_comb
      assign s2_next_free = out_ready;
      assign out_valid    = s2_valid_q;
      assign y            = res.y;
      assign ovf          = res.ovf;
    end
  endgenerate

endmodule

// File: tb/tb_fsub_pipe.sv
// Directed self-checking bench for fsub_pipe: vector table plus backpressure and reset sequences.
module tb_fsub_pipe;

  localparam int unsigned OUT_REG = 1;
  localparam int          LAT     = (OUT_REG != 0) ? 3 : 2;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] y;
    logic        ovf;
  } vec_t;

  logic        clk = 1'b0, rstn = 1'b0;
  logic        in_valid = 1'b0, out_ready = 1'b0;
  logic        in_ready, out_valid, ovf;
  logic [31:0] x1 = '0, x2 = '0, y;
  int          passed = 0, total = 0;

  fsub_pipe #(.OUT_REG(OUT_REG)) dut (
    .clk       (clk),
    .rstn      (rstn),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .x1        (x1),
    .x2        (x2),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .y         (y),
    .ovf       (ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act === req) passed++;
    else $display("FAIL %s: got %h, expected %h", nm, act, req);
  endtask

  task automatic run_op(input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] ry, output logic rovf, output int lat);
    @(negedge clk);
    x1 = a; x2 = b; in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    lat = 0; ry = '0; rovf = 1'b0;
    for (int c = 1; c <= 10 && lat == 0; c++) begin
      @(negedge clk);
      if (out_valid) begin
        lat = c; ry = y; rovf = ovf;
      end
    end
    @(posedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t        vecs[$];
    logic [31:0] ry;
    logic        rovf;
    int          lat;
    logic [31:0] bp_a[6], bp_b[6], bp_y[6];
    int          sent, rcv, drop_at, stale;
    logic        acc, xfer, seen;

    vecs.push_back({32'h3f800000, 32'h3f800000, 32'h00000000, 1'b0});
    vecs.push_back({32'h7f7fffff, 32'hff7fffff, 32'h7f800000, 1'b1});
    vecs.push_back({32'h7f800000, 32'h3f800000, 32'h7f800000, 1'b0});
    vecs.push_back({32'h7f800000, 32'h7f800000, 32'h7fc00000, 1'b0});
    vecs.push_back({32'h3f800000, 32'h33000000, 32'h3f800000, 1'b0});
    vecs.push_back({32'h3f800001, 32'h33000000, 32'h3f800001, 1'b0});
    vecs.push_back({32'h7f7fffff, 32'hf3000000, 32'h7f800000, 1'b1});
    vecs.push_back({32'h00000000, 32'h00000000, 32'h00000000, 1'b0});
    vecs.push_back({32'h80000000, 32'h00000000, 32'h80000000, 1'b0});
    vecs.push_back({32'h00000000, 32'h80000000, 32'h00000000, 1'b0});
    vecs.push_back({32'h80000000, 32'h80000000, 32'h00000000, 1'b0});
    vecs.push_back({32'h7fa00000, 32'h3f800000, 32'h7fe00000, 1'b0});
    vecs.push_back({32'h3f800000, 32'hffa00001, 32'hffe00001, 1'b0});
    vecs.push_back({32'h7fa00000, 32'h7f900000, 32'h7fe00000, 1'b0});
    vecs.push_back({32'h3f800000, 32'h7f800000, 32'hff800000, 1'b0});
    vecs.push_back({32'hff800000, 32'h7f800000, 32'hff800000, 1'b0});
    vecs.push_back({32'h40400000, 32'h3f800000, 32'h40000000, 1'b0});
    vecs.push_back({32'h3f800000, 32'h40400000, 32'hc0000000, 1'b0});
    vecs.push_back({32'h40000000, 32'hc0000000, 32'h40800000, 1'b0});
    vecs.push_back({32'h3f800000, 32'h3f7fffff, 32'h33800000, 1'b0});
`ifdef FSUB_DENORM_EN
    vecs.push_back({32'h00000002, 32'h00000001, 32'h00000001, 1'b0});
    vecs.push_back({32'h00800000, 32'h00000001, 32'h007fffff, 1'b0});
    vecs.push_back({32'h00800001, 32'h00800000, 32'h00000001, 1'b0});
    vecs.push_back({32'h80000001, 32'h00000001, 32'h80000002, 1'b0});
`else
    vecs.push_back({32'h00000002, 32'h00000001, 32'h00000000, 1'b0});
    vecs.push_back({32'h00800000, 32'h00000001, 32'h00800000, 1'b0});
    vecs.push_back({32'h00800001, 32'h00800000, 32'h00000000, 1'b0});
    vecs.push_back({32'h80000001, 32'h00000001, 32'h80000000, 1'b0});
`endif

    bp_a = '{32'h40400000, 32'h40a00000, 32'h3f800000, 32'h41200000, 32'h00000000, 32'h42c80000};
    bp_b = '{32'h3f800000, 32'h40000000, 32'h40000000, 32'h3f800000, 32'h3f800000, 32'h42c80000};
    bp_y = '{32'h40000000, 32'h40400000, 32'hbf800000, 32'h41100000, 32'hbf800000, 32'h00000000};

    // Reset state
    #12;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_y", y, 32'h0);
    chk("rst_ovf", 32'(ovf), 32'd0);
    @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    chk("rst_in_ready", 32'(in_ready), 32'd1);

    // Vector table, one op at a time
    for (int i = 0; i < vecs.size(); i++) begin
      run_op(vecs[i].a, vecs[i].b, ry, rovf, lat);
      chk($sformatf("v%0d_y", i), ry, vecs[i].y);
      chk($sformatf("v%0d_ovf", i), 32'(rovf), 32'(vecs[i].ovf));
      chk($sformatf("v%0d_lat", i), 32'(lat), 32'(LAT));
    end

    // Backpressure: six back-to-back ops, consumer stalled for the first 5 cycles
    sent = 0; rcv = 0; drop_at = -1;
    for (int cyc = 0; cyc < 40 && rcv < 6; cyc++) begin
      @(negedge clk);
      out_ready = (cyc >= 5);
      in_valid  = (sent < 6);
      if (sent < 6) begin
        x1 = bp_a[sent]; x2 = bp_b[sent];
      end
      #1;
      if (!in_ready && drop_at < 0) drop_at = sent;
      if (out_valid) chk($sformatf("bp_y%0d", rcv), y, bp_y[rcv]);
      acc  = in_valid && in_ready;
      xfer = out_valid && out_ready;
      @(posedge clk);
      if (acc)  sent++;
      if (xfer) rcv++;
    end
    #1 in_valid = 1'b0;
    chk("bp_drop_at", 32'(drop_at), 32'(LAT));
    chk("bp_count", 32'(rcv), 32'd6);

    // Reset with two ops in flight and a result waiting
    @(negedge clk);
    out_ready = 1'b0; in_valid = 1'b1; x1 = 32'h40400000; x2 = 32'h3f800000;
    @(posedge clk);
    #1 x1 = 32'h40a00000; x2 = 32'h40000000;
    @(posedge clk);
    #1 in_valid = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 10 && !seen; c++) begin
      @(negedge clk);
      seen = out_valid;
    end
    chk("rst_pre_valid", 32'(seen), 32'd1);
    #2 rstn = 1'b0;
    #1 chk("rst_async_valid", 32'(out_valid), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rstn = 1'b1; out_ready = 1'b1;
    stale = 0;
    repeat (8) begin
      @(negedge clk);
      if (out_valid) stale++;
    end
    chk("rst_no_stale", 32'(stale), 32'd0);
    run_op(32'h3fc00000, 32'h3f800000, ry, rovf, lat);
    chk("post_rst_y", ry, 32'h3f000000);
    chk("post_rst_lat", 32'(lat), 32'(LAT));

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
